// File: rtl/axi_rd_arbiter_if.sv
// axi_rd_arbiter_if
// One AXI read-channel link (AR + R) between a requester and a responder.
//   master modport : drives ar_valid/ar_addr/ar_len/ar_size and r_ready,
//                    receives ar_ready and r_valid/r_data/r_resp/r_last.
//   slave modport  : the mirror image.
// ar_len is one bit: 0 = single beat, 1 = two-beat burst.
interface axi_rd_arbiter_if #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64
);
  logic                      ar_valid;
  logic                      ar_ready;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic                      ar_len;
  logic [2:0]                ar_size;
  logic                      r_valid;
  logic                      r_ready;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;

  modport master (
    output ar_valid, ar_addr, ar_len, ar_size, r_ready,
    input  ar_ready, r_valid, r_data, r_resp, r_last
  );

  modport slave (
    input  ar_valid, ar_addr, ar_len, ar_size, r_ready,
    output ar_ready, r_valid, r_data, r_resp, r_last
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter
// Two-master to one-slave AXI read arbiter (m0 = IFU, m1 = LSU) in front of
// the SRAM slave. One transaction outstanding at a time; the winner owns AR
// and R until its last R beat is accepted.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   m0, m1   : requester links (slave modport of axi_rd_arbiter_if)
//   s        : downstream link to the SRAM slave (master modport)
// Build option:
//   AXI_RD_ARB_RR_EN defined   -> round-robin tie-break (m1 wins first tie)
//   AXI_RD_ARB_RR_EN undefined -> fixed priority, m1 wins every tie
// AR and R paths are pure muxes; only the state and grant are registered.
module axi_rd_arbiter #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64
) (
  input logic              clk,
  input logic              rst,
  axi_rd_arbiter_if.slave  m0,
  axi_rd_arbiter_if.slave  m1,
  axi_rd_arbiter_if.master s
);

  typedef enum logic [1:0] {IDLE, AR, R} state_t;

  state_t                    state;
  logic                      gnt;
  logic                      gnt_next;
  logic                      sel_ar_valid;
  logic [AXI_ADDR_WIDTH-1:0] sel_ar_addr;
  logic                      sel_ar_len;
  logic [2:0]                sel_ar_size;
  logic                      sel_r_ready;
  logic                      ar_fire;
  logic                      r_done;

`ifdef AXI_RD_ARB_RR_EN
  // Master served by the most recent completed transaction; reset to m0 so
  // that the first tie goes to m1.
  logic last_served;

  always_comb begin
    if (m0.ar_valid && m1.ar_valid) gnt_next = ~last_served;
    else                            gnt_next = m1.ar_valid;
  end
`else
  // m1 wins a tie; a lone requester wins either way.
  always_comb gnt_next = m1.ar_valid;
`endif

  assign sel_ar_valid = gnt ? m1.ar_valid : m0.ar_valid;
  assign sel_ar_addr  = gnt ? m1.ar_addr  : m0.ar_addr;
  assign sel_ar_len   = gnt ? m1.ar_len   : m0.ar_len;
  assign sel_ar_size  = gnt ? m1.ar_size  : m0.ar_size;
  assign sel_r_ready  = gnt ? m1.r_ready  : m0.r_ready;

  assign ar_fire = (state == AR) && sel_ar_valid && s.ar_ready;
  // Only the beat flagged last ends the grant; earlier burst beats stay in R.
  assign r_done  = (state == R) && s.r_valid && sel_r_ready && s.r_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 1'b0;
`ifdef AXI_RD_ARB_RR_EN
      last_served <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (m0.ar_valid || m1.ar_valid) begin
            gnt   <= gnt_next;
            state <= AR;
          end
        end
        AR: begin
          // A granted master that drops ar_valid simply parks us here.
          if (ar_fire) state <= R;
        end
        R: begin
          if (r_done) begin
            state <= IDLE;
`ifdef AXI_RD_ARB_RR_EN
            last_served <= gnt;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output steering: everything is zero unless the state routes it.
  always_comb begin
    s.ar_valid  = 1'b0;
    s.ar_addr   = {AXI_ADDR_WIDTH{1'b0}};
    s.ar_len    = 1'b0;
    s.ar_size   = 3'd0;
    s.r_ready   = 1'b0;
    m0.ar_ready = 1'b0;
    m0.r_valid  = 1'b0;
    m0.r_data   = {AXI_DATA_WIDTH{1'b0}};
    m0.r_resp   = 2'd0;
    m0.r_last   = 1'b0;
    m1.ar_ready = 1'b0;
    m1.r_valid  = 1'b0;
    m1.r_data   = {AXI_DATA_WIDTH{1'b0}};
    m1.r_resp   = 2'd0;
    m1.r_last   = 1'b0;
    case (state)
      AR: begin
        s.ar_valid = sel_ar_valid;
        s.ar_addr  = sel_ar_addr;
        s.ar_len   = sel_ar_len;
        s.ar_size  = sel_ar_size;
        if (gnt) m1.ar_ready = s.ar_ready;
        else     m0.ar_ready = s.ar_ready;
      end
      R: begin
        s.r_ready = sel_r_ready;
        if (gnt) begin
          m1.r_valid = s.r_valid;
          m1.r_data  = s.r_data;
          m1.r_resp  = s.r_resp;
          m1.r_last  = s.r_last;
        end else begin
          m0.r_valid = s.r_valid;
          m0.r_data  = s.r_data;
          m0.r_resp  = s.r_resp;
          m0.r_last  = s.r_last;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter
// Directed scenarios followed by randomized traffic. A transaction-level
// reference (who owns the bus, whether its address is still pending) predicts
// every DUT output each cycle; inputs change 1 time unit after posedge and
// outputs are sampled on negedge.
module tb_axi_rd_arbiter;
  localparam int AW = 32;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_rd_arbiter_if #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) m0_if ();
  axi_rd_arbiter_if #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) m1_if ();
  axi_rd_arbiter_if #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) s_if ();

  axi_rd_arbiter #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .m0  (m0_if),
    .m1  (m1_if),
    .s   (s_if)
  );

  // Bench-driven inputs
  logic          mv[2];
  logic [AW-1:0] ma[2];
  logic          ml[2];
  logic [2:0]    ms[2];
  logic          mrr[2];
  logic          sar_rdy, srv, srl;
  logic [DW-1:0] srd;
  logic [1:0]    srresp;

  assign m0_if.ar_valid = mv[0];
  assign m0_if.ar_addr  = ma[0];
  assign m0_if.ar_len   = ml[0];
  assign m0_if.ar_size  = ms[0];
  assign m0_if.r_ready  = mrr[0];
  assign m1_if.ar_valid = mv[1];
  assign m1_if.ar_addr  = ma[1];
  assign m1_if.ar_len   = ml[1];
  assign m1_if.ar_size  = ms[1];
  assign m1_if.r_ready  = mrr[1];
  assign s_if.ar_ready  = sar_rdy;
  assign s_if.r_valid   = srv;
  assign s_if.r_data    = srd;
  assign s_if.r_resp    = srresp;
  assign s_if.r_last    = srl;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  int            owner = -1;   // -1: bus free, else owning master
  bit            aphase = 1'b0; // owner's address not yet accepted
  int            hist = 0;     // master of last completed transaction
  bit            mdl_ok = 1'b0;
  bit            rr_mode;
  int            ar_hs_m, r_hs_m;
  int            n_done = 0;
  logic [AW-1:0] obs_ar[$];

  task automatic step();
    logic [36:0] e_sar;
    logic [68:0] e_m[2];
    logic        e_srr;
    int          n_owner, n_hist;
    bit          n_aphase;
    @(negedge clk);
    e_sar  = '0;
    e_m[0] = '0;
    e_m[1] = '0;
    e_srr  = 1'b0;
    ar_hs_m = -1;
    r_hs_m  = -1;
    if (owner >= 0 && aphase) begin
      e_sar = {mv[owner], ma[owner], ml[owner], ms[owner]};
      e_m[owner] = {sar_rdy, 68'd0};
    end else if (owner >= 0) begin
      e_m[owner] = {1'b0, srv, srd, srresp, srl};
      e_srr = mrr[owner];
    end
    if (mdl_ok) begin
      chk("s_ar", 128'({s_if.ar_valid, s_if.ar_addr, s_if.ar_len, s_if.ar_size}), 128'(e_sar));
      chk("m0", 128'({m0_if.ar_ready, m0_if.r_valid, m0_if.r_data, m0_if.r_resp, m0_if.r_last}), 128'(e_m[0]));
      chk("m1", 128'({m1_if.ar_ready, m1_if.r_valid, m1_if.r_data, m1_if.r_resp, m1_if.r_last}), 128'(e_m[1]));
      chk("s_r_ready", 128'(s_if.r_ready), 128'(e_srr));
    end
    if (s_if.ar_valid && s_if.ar_ready) obs_ar.push_back(s_if.ar_addr);
    n_owner = owner; n_aphase = aphase; n_hist = hist;
    if (rst) begin
      n_owner = -1; n_aphase = 1'b0; n_hist = 0;
    end else if (owner < 0) begin
      if (mv[0] || mv[1]) begin
        if (mv[0] && mv[1]) n_owner = rr_mode ? 1 - hist : 1;
        else                n_owner = mv[1] ? 1 : 0;
        n_aphase = 1'b1;
      end
    end else if (aphase) begin
      if (mv[owner] && sar_rdy) begin
        n_aphase = 1'b0;
        ar_hs_m = owner;
      end
    end else if (srv && mrr[owner]) begin
      r_hs_m = owner;
      if (srl) begin
        n_owner = -1;
        n_hist = owner;
        n_done++;
      end
    end
    @(posedge clk);
    owner = n_owner; aphase = n_aphase; hist = n_hist;
    if (rst) mdl_ok = 1'b1;
    #1;
  endtask

  task automatic idle_all();
    for (int k = 0; k < 2; k++) begin
      mv[k] = 1'b0; ma[k] = '0; ml[k] = 1'b0; ms[k] = 3'd3; mrr[k] = 1'b1;
    end
    sar_rdy = 1'b0; srv = 1'b0; srl = 1'b0; srd = '0; srresp = 2'd0;
  endtask

  initial begin
    bit            sl_busy;
    logic [AW-1:0] sl_addr;
    logic          sl_len;
    int            sl_beat;
    int            n_before;
    logic [AW-1:0] exp_a;
`ifdef AXI_RD_ARB_RR_EN
    rr_mode = 1'b1;
`else
    rr_mode = 1'b0;
`endif
    idle_all();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_s_ar", 128'({s_if.ar_valid, s_if.ar_addr, s_if.r_ready}), 128'(0));
    chk("rst_m0", 128'({m0_if.ar_ready, m0_if.r_valid, m0_if.r_last}), 128'(0));

    // Single IFU read
    mv[0] = 1'b1; ma[0] = 32'h8000_0000; srv = 1'b1; srl = 1'b1; srd = 64'hDEAD;
    #1 chk("t1_idle_outputs", 128'({s_if.ar_valid, m0_if.r_valid}), 128'(0));
    srv = 1'b0; srl = 1'b0;
    step();
    #1 chk("t1_sarv_next", 128'(s_if.ar_valid), 128'(1));
    chk("t1_addr", 128'(s_if.ar_addr), 128'(32'h8000_0000));
    sar_rdy = 1'b1;
    #1 chk("t1_m0_arready", 128'(m0_if.ar_ready), 128'(1));
    step();
    mv[0] = 1'b0; sar_rdy = 1'b0;
    srv = 1'b1; srl = 1'b1; srd = 64'h1122334455667788;
    #1 chk("t1_data", 128'(m0_if.r_data), 128'(64'h1122334455667788));
    chk("t1_last", 128'(m0_if.r_last), 128'(1));
    chk("t1_m1_novalid", 128'(m1_if.r_valid), 128'(0));
    step();
    #1 chk("t1_back_idle", 128'({m0_if.r_valid, s_if.r_ready}), 128'(0));
    idle_all();
    step();

    // Simultaneous requests
    mv[0] = 1'b1; ma[0] = 32'h8000_0000; mv[1] = 1'b1; ma[1] = 32'h8000_0100;
    step();
    #1 chk("t2_first_m1", 128'(s_if.ar_addr), 128'(32'h8000_0100));
    sar_rdy = 1'b1;
    step();
    mv[1] = 1'b0; sar_rdy = 1'b0; srv = 1'b1; srl = 1'b1; srd = 64'h0101;
    #1 chk("t2_m1_data", 128'(m1_if.r_data), 128'(64'h0101));
    step();  // last beat edge n
    srv = 1'b0; srl = 1'b0;
    #1 chk("t2_gap_n1", 128'(s_if.ar_valid), 128'(0));
    step();
    #1 chk("t2_m0_ar_n2", 128'(s_if.ar_valid), 128'(1));
    chk("t2_m0_addr", 128'(s_if.ar_addr), 128'(32'h8000_0000));
    sar_rdy = 1'b1;
    step();
    mv[0] = 1'b0; srv = 1'b1; srl = 1'b1; srd = 64'h0202;
    step();
    idle_all();
    step();

    // Continuous contention: four grants
    obs_ar.delete();
    mv[0] = 1'b1; ma[0] = 32'h8000_1000; mv[1] = 1'b1; ma[1] = 32'h8000_2000;
    sar_rdy = 1'b1; srv = 1'b1; srl = 1'b1; srd = 64'h3333;
    repeat (12) step();
    idle_all();
    chk("t3_count", 128'(obs_ar.size()), 128'(4));
    for (int i = 0; i < 4; i++) begin
      exp_a = (!rr_mode || (i % 2 == 0)) ? 32'h8000_2000 : 32'h8000_1000;
      chk($sformatf("t3_grant%0d", i), 128'((i < obs_ar.size()) ? obs_ar[i] : '0), 128'(exp_a));
    end
    step();

    // 2-beat burst with competing m0
    mv[1] = 1'b1; ma[1] = 32'h8000_0200; ml[1] = 1'b1;
    step();
    mv[0] = 1'b1; ma[0] = 32'h8000_0000; sar_rdy = 1'b1;
    step();
    mv[1] = 1'b0; srv = 1'b1; srl = 1'b0; srd = 64'hAAAA;
    #1 chk("t4_beat0", 128'(m1_if.r_data), 128'(64'hAAAA));
    chk("t4_beat0_last", 128'(m1_if.r_last), 128'(0));
    step();
    srd = 64'hBBBB; srl = 1'b1;
    #1 chk("t4_beat1", 128'(m1_if.r_data), 128'(64'hBBBB));
    chk("t4_m0_held", 128'({s_if.ar_valid, m0_if.ar_ready}), 128'(0));
    step();
    srv = 1'b0; srl = 1'b0;
    #1 chk("t4_gap", 128'(s_if.ar_valid), 128'(0));
    step();
    #1 chk("t4_m0_ar", 128'({s_if.ar_valid, s_if.ar_addr}), 128'({1'b1, 32'h8000_0000}));
    step();
    mv[0] = 1'b0; srv = 1'b1; srl = 1'b1; srd = 64'h4444;
    step();
    idle_all();
    step();

    // Backpressure on m0
    mv[0] = 1'b1; ma[0] = 32'h8000_0400; mrr[0] = 1'b0; sar_rdy = 1'b1;
    step(); step();
    mv[0] = 1'b0; sar_rdy = 1'b0; srv = 1'b1; srl = 1'b1; srd = 64'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t5_s_r_ready_low", 128'(s_if.r_ready), 128'(0));
      chk("t5_valid_shown", 128'(m0_if.r_valid), 128'(1));
      step();
    end
    mrr[0] = 1'b1;
    #1 chk("t5_release", 128'(s_if.r_ready), 128'(1));
    chk("t5_data", 128'(m0_if.r_data), 128'(64'hCAFE_F00D));
    step();
    idle_all();
    step();

    // Reset in R before the last beat
    mv[0] = 1'b1; ma[0] = 32'h8000_0500; ml[0] = 1'b1; sar_rdy = 1'b1;
    step(); step();
    mv[0] = 1'b0; sar_rdy = 1'b0; srv = 1'b1; srl = 1'b0; srd = 64'h1111;
    step();
    rst = 1'b1; srd = 64'h2222; srl = 1'b1;
    step();
    rst = 1'b0;
    #1 chk("t6_s_ar_zero", 128'({s_if.ar_valid, s_if.ar_addr, s_if.r_ready}), 128'(0));
    chk("t6_m0_zero", 128'({m0_if.ar_ready, m0_if.r_valid, m0_if.r_data, m0_if.r_last}), 128'(0));
    srv = 1'b0; srl = 1'b0;
    step();
    mv[0] = 1'b1; ma[0] = 32'h8000_0600; ml[0] = 1'b0;
    step();
    #1 chk("t6_fresh_ar", 128'({s_if.ar_valid, s_if.ar_addr}), 128'({1'b1, 32'h8000_0600}));
    sar_rdy = 1'b1;
    step();
    mv[0] = 1'b0; sar_rdy = 1'b0; srv = 1'b1; srl = 1'b1; srd = 64'h5555;
    #1 chk("t6_fresh_data", 128'(m0_if.r_data), 128'(64'h5555));
    step();
    idle_all();
    step();

    // Randomized traffic
    n_before = n_done;
    sl_busy = 1'b0; sl_addr = '0; sl_len = 1'b0; sl_beat = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!mv[k] && ($urandom % 4 == 0)) begin
          mv[k] = 1'b1;
          ma[k] = $urandom & 32'hFFFF_FFF8;
          ml[k] = 1'($urandom % 2);
          ms[k] = 3'($urandom % 4);
        end
        mrr[k] = ($urandom % 4) != 0;
      end
      sar_rdy = 1'($urandom % 2);
      srresp = 2'($urandom);
      if (sl_busy) begin
        srv = ($urandom % 4) != 0;
        srd = {sl_addr, 24'h0, 8'(sl_beat)};
        srl = (sl_beat == int'(sl_len));
      end else begin
        srv = 1'($urandom % 2);
        srd = {$urandom, $urandom};
        srl = 1'($urandom % 2);
      end
      rst = ($urandom % 400) == 0;
      step();
      if (rst) begin
        sl_busy = 1'b0;
      end else begin
        if (ar_hs_m >= 0) begin
          sl_busy = 1'b1;
          sl_addr = ma[ar_hs_m];
          sl_len  = ml[ar_hs_m];
          sl_beat = 0;
          mv[ar_hs_m] = 1'b0;
        end
        if (r_hs_m >= 0) begin
          if (srl) sl_busy = 1'b0;
          else     sl_beat++;
        end
      end
    end
    rst = 1'b0;
    chk("rand_txns", 128'((n_done - n_before) > 50), 128'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
